key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- Input-side counterpart of the board's scanned seven-segment display: drives a 4x4 matrix keypad one row at a time (active low), reads the columns, debounces, and emits 4-bit key codes.
- Key codes are hex values 0-F, ready to feed a display digit value or a CPU-readable register.
- Scan timing shares the display's 1 ms-per-slot convention at 50 MHz.

Parameters:
- SCAN_DIV, 16'd49999: tick period minus one, in clk cycles; one tick = one row dwell and one debounce sample.
- DEB_COUNT, 8'd20: consecutive identical samples (ticks) required to accept a press or a release; legal range 1..255.

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- en  in  1  active-high enable
- col_n  in  4  keypad column inputs, active low, asynchronous, pulled up on the board
- row_n  out  4  keypad row drive, active low, one-hot-low
- key_code  out  4  code of the last accepted key, {row[1:0], col[1:0]}
- key_valid  out  1  new-key flag; held until consumed
- key_ready  in  1  consumer acknowledge; key_valid clears on the cycle after key_valid & key_ready
- key_held  out  1  level; high while the accepted key is still debounced-pressed
- overflow  out  1  one-cycle pulse when a key is accepted while key_valid is still set

Behaviour:
- Reset values: row_n=4'b1110 (row 0), key_code=0, key_valid=0, key_held=0, overflow=0, state SCAN, divider=0, deb_cnt=0.
- col_n passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick: the divider counts 0..SCAN_DIV. tick is a 1-cycle strobe when divider==SCAN_DIV, and the divider wraps to 0 on that cycle.
- Column samples are taken only on tick cycles, giving a full dwell of settling after a row change.
- Column priority: the lowest-index low column wins (col 0 > col 3).
- State SCAN:
  - On tick with all columns high: rotate to the next row (3 wraps to 0).
  - On tick with any column low: latch cur_row and cur_col, set deb_cnt=1, hold the row.
  - Go to DEBOUNCE, or go straight to HELD if DEB_COUNT==1.
- State DEBOUNCE (row frozen). On tick:
  - Latched column low: deb_cnt+1. When deb_cnt reaches DEB_COUNT, go to HELD.
  - Latched column high: deb_cnt=0, go to SCAN, advance to the next row.
- Entry to HELD (accept), registered and visible on the cycle after the accepting tick:
  - key_code={cur_row,cur_col}, key_valid=1, key_held=1.
  - If key_valid was already 1 and not being consumed that cycle, key_code is still overwritten and overflow pulses for one cycle.
- State HELD. On tick:
  - Latched column high: deb_cnt=1, go to RELEASE (or straight to release-complete if DEB_COUNT==1).
  - Other columns in the frozen row are ignored (no rollover).
- State RELEASE. On tick:
  - Latched column high: deb_cnt+1. At DEB_COUNT: key_held=0, go to SCAN, advance to the next row.
  - Latched column low: go back to HELD, deb_cnt=0.
- Handshake:
  - key_valid & key_ready clears key_valid the next cycle.
  - key_ready with key_valid low has no effect.
  - Accept and consume in the same cycle: the new key wins, key_valid stays 1, no overflow.
- en=0, effective next cycle:
  - row_n=4'b1111, divider held at 0, state forced to SCAN with row pointer 0, key_held=0.
  - key_valid and key_code are retained, and the handshake still works.
  - On en rising, scanning restarts at row 0 with row_n=4'b1110.
- Reset mid-debounce or mid-hold returns every state to its reset value. A pending key is discarded.
- Latency from a stable press to key_valid: at most 4×(SCAN_DIV+1) + DEB_COUNT×(SCAN_DIV+1) + 3 cycles.

Decomposition:
- Package key_scan_pkg holds:
  - state encoding: SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3
  - ROW0_N=4'b1110
  - ROW_IDLE_N=4'b1111
  - default SCAN_DIV and DEB_COUNT constants
- Sub-module sync_2ff (parameterised width, 2-flop synchronizer) for col_n; it is reusable for push-button inputs.
- Tick divider and FSM stay in key_matrix_scan.

Test Plan (SCAN_DIV=3, DEB_COUNT=3):
- Reset then idle, all col_n=1 → row_n cycles 1110→1101→1011→0111→1110, one step every 4 clk; key_valid stays 0.
- Hold col 2 low only while row_n=1011, for ≥5 ticks → row freezes at 1011. key_code=4'hA and key_valid=1 the cycle after the 3rd matching tick; key_held=1.
- Key 0xA press with a 2-tick glitch, then release → no key_valid; scanning resumes at row 3 (0111).
- Accept 0x5 with key_ready=0, release, then accept 0xF → key_code=0xF, key_valid stays 1, overflow pulses exactly once. Then key_ready=1 for 1 cycle → key_valid=0 next cycle.
- Hold a key, release for 2 ticks, re-press → stays HELD; key_held stays 1; no second key_valid.
- Drop en during DEBOUNCE → row_n=1111 next cycle, no key emitted. Raise en → row_n=1110, scan restarts at row 0. Pulse reset_n low while key_valid=1 → all outputs return to their reset values.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared encodings and helpers for the 4x4 keypad scanner.
package key_scan_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0]  ROW0_N            = 4'b1110;
    localparam logic [3:0]  ROW_IDLE_N        = 4'b1111;
    localparam logic [15:0] SCAN_DIV_DEFAULT  = 16'd49999;
    localparam logic [7:0]  DEB_COUNT_DEFAULT = 8'd20;

    // Lowest-index low column wins; only meaningful when some column is low.
    function automatic logic [1:0] first_low_col(input logic [3:0] cols_n);
        if (!cols_n[0])      return 2'd0;
        else if (!cols_n[1]) return 2'd1;
        else if (!cols_n[2]) return 2'd2;
        else                 return 2'd3;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad columns, push buttons).
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make both flops sample together, so the
    // chain really is two stages deep regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: rotates an active-low row drive, debounces the column
// returns on a slow tick and emits hex key codes with a valid/ready handshake.
module key_matrix_scan
    import key_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = SCAN_DIV_DEFAULT,
    parameter logic [7:0]  DEB_COUNT = DEB_COUNT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);

    logic [3:0]  col_s;
    logic [15:0] divider;
    logic        tick;
    logic        scan_on;

    scan_state_t state, state_nxt;
    logic [1:0]  row_ptr, row_nxt;
    logic [1:0]  col_lat, col_nxt;
    logic [7:0]  deb_cnt, deb_nxt;
    logic        accept;
    logic        release_done;

    logic        any_low;
    logic        latched_low;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (col_n),
        .q       (col_s)
    );

    assign tick        = en && (divider == SCAN_DIV);
    assign any_low     = ~&col_s;
    assign latched_low = ~col_s[col_lat];
    assign row_n       = scan_on ? row_drive(row_ptr) : ROW_IDLE_N;

    always_ff @(posedge clk) begin
        if (!reset_n)   divider <= '0;
        else if (!en)   divider <= '0;
        else if (tick)  divider <= '0;
        else            divider <= divider + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)  state <= SCAN;
        else if (!en)  state <= SCAN;
        else           state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        row_nxt      = row_ptr;
        col_nxt      = col_lat;
        deb_nxt      = deb_cnt;
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (any_low) begin
                        col_nxt = first_low_col(col_s);
                        deb_nxt = 8'd1;
                        if (DEB_COUNT == 8'd1) begin
                            state_nxt = HELD;
                            accept    = 1'b1;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        row_nxt = row_ptr + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (latched_low) begin
                        deb_nxt = deb_cnt + 8'd1;
                        if (deb_nxt == DEB_COUNT) begin
                            state_nxt = HELD;
                            accept    = 1'b1;
                        end
                    end else begin
                        deb_nxt   = 8'd0;
                        state_nxt = SCAN;
                        row_nxt   = row_ptr + 2'd1;
                    end
                end
                HELD: begin
                    // Other columns in the frozen row are deliberately ignored.
                    if (!latched_low) begin
                        deb_nxt = 8'd1;
                        if (DEB_COUNT == 8'd1) begin
                            state_nxt    = SCAN;
                            row_nxt      = row_ptr + 2'd1;
                            release_done = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (!latched_low) begin
                        deb_nxt = deb_cnt + 8'd1;
                        if (deb_nxt == DEB_COUNT) begin
                            state_nxt    = SCAN;
                            row_nxt      = row_ptr + 2'd1;
                            release_done = 1'b1;
                        end
                    end else begin
                        deb_nxt   = 8'd0;
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scan_on  <= 1'b1;
            row_ptr  <= 2'd0;
            col_lat  <= 2'd0;
            deb_cnt  <= 8'd0;
            key_held <= 1'b0;
        end else if (!en) begin
            scan_on  <= 1'b0;
            row_ptr  <= 2'd0;
            deb_cnt  <= 8'd0;
            key_held <= 1'b0;
        end else begin
            scan_on <= 1'b1;
            row_ptr <= row_nxt;
            col_lat <= col_nxt;
            deb_cnt <= deb_nxt;
            if (accept)            key_held <= 1'b1;
            else if (release_done) key_held <= 1'b0;
        end
    end

    // Handshake runs regardless of en so a parked key can still be consumed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= accept && key_valid && !key_ready;
            if (accept) begin
                key_code  <= {row_ptr, col_nxt};
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench: physical keypad model plus a tick-level reference of the scanner.
module tb_key_matrix_scan;

    localparam int SD = 3;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic        key_ready = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        overflow;
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int errors = 0;

    key_matrix_scan #(.SCAN_DIV(16'(SD)), .DEB_COUNT(8'(DC))) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column to its row; undriven columns float high.
    function automatic logic [3:0] keypad(input logic [3:0] rows, input logic [15:0] keys);
        logic [3:0] cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
        return cols;
    endfunction

    assign col_n = keypad(row_n, pressed);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: scanning row, a candidate key and a streak of agreeing ticks.
    bit         m_on = 1'b1;
    int         m_row = 0;
    int         m_mode = 0;     // 0 looking, 1 confirming press, 2 holding, 3 confirming release
    int         m_col = 0;
    int         m_streak = 0;
    int         m_phase = 0;
    logic [3:0] m_code = 4'd0;
    bit         m_valid = 1'b0;
    bit         m_held = 1'b0;
    bit         m_ovf = 1'b0;
    logic [3:0] m_s1 = 4'hF;
    logic [3:0] m_s2 = 4'hF;

    int  ovf_seen = 0;
    int  valid_rises = 0;
    int  held_falls = 0;
    bit  prev_valid = 1'b0;
    bit  prev_held = 1'b0;

    function automatic logic [3:0] exp_rows();
        logic [3:0] r = 4'hF;
        if (m_on) r[m_row] = 1'b0;
        return r;
    endfunction

    task automatic model_step();
        logic [3:0] h = keypad(exp_rows(), pressed);
        logic [3:0] samp = m_s2;
        bit tick, accept, rel;
        int low_col;
        accept = 1'b0;
        rel    = 1'b0;
        if (!reset_n) begin
            m_on = 1'b1; m_row = 0; m_mode = 0; m_col = 0; m_streak = 0; m_phase = 0;
            m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0; m_ovf = 1'b0;
            m_s1 = 4'hF; m_s2 = 4'hF;
            return;
        end
        tick = en && (m_phase == SD);
        low_col = -1;
        for (int c = 3; c >= 0; c--) if (!samp[c]) low_col = c;
        if (!en) begin
            m_on = 1'b0; m_row = 0; m_mode = 0; m_streak = 0; m_phase = 0; m_held = 1'b0;
        end else begin
            m_on = 1'b1;
            m_phase = tick ? 0 : m_phase + 1;
            if (tick) begin
                if (m_mode == 0) begin
                    if (low_col >= 0) begin
                        m_col = low_col; m_streak = 1;
                        if (m_streak == DC) begin m_mode = 2; accept = 1'b1; end
                        else m_mode = 1;
                    end else m_row = (m_row + 1) % 4;
                end else if (m_mode == 1) begin
                    if (!samp[m_col]) begin
                        m_streak++;
                        if (m_streak == DC) begin m_mode = 2; accept = 1'b1; end
                    end else begin
                        m_streak = 0; m_mode = 0; m_row = (m_row + 1) % 4;
                    end
                end else if (m_mode == 2) begin
                    if (samp[m_col]) begin
                        m_streak = 1;
                        if (m_streak == DC) begin rel = 1'b1; m_mode = 0; m_row = (m_row + 1) % 4; end
                        else m_mode = 3;
                    end
                end else begin
                    if (samp[m_col]) begin
                        m_streak++;
                        if (m_streak == DC) begin rel = 1'b1; m_mode = 0; m_row = (m_row + 1) % 4; end
                    end else begin
                        m_streak = 0; m_mode = 2;
                    end
                end
            end
            if (accept) m_held = 1'b1;
            else if (rel) m_held = 1'b0;
        end
        m_ovf = accept && m_valid && !key_ready;
        if (accept) begin
            m_valid = 1'b1;
            m_code  = 4'(m_row * 4 + m_col);
        end else if (m_valid && key_ready) begin
            m_valid = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = h;
    endtask

    always @(negedge clk) begin
        check("row_n", row_n, exp_rows());
        check("key_code", key_code, m_code);
        check("key_valid", key_valid, m_valid);
        check("key_held", key_held, m_held);
        check("overflow", overflow, m_ovf);
        if (overflow === 1'b1) ovf_seen++;
        if (key_valid === 1'b1 && !prev_valid) valid_rises++;
        if (key_held === 1'b0 && prev_held) held_falls++;
        prev_valid = (key_valid === 1'b1);
        prev_held  = (key_held === 1'b1);
        model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick(input int sel);
        case (sel)
            0:       return row_n;
            1:       return {3'b000, key_valid};
            2:       return {3'b000, key_held};
            default: return key_code;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input logic [3:0] val, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (pick(sel) === val) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic pulse_ready();
        step(); key_ready = 1'b1;
        step(); key_ready = 1'b0;
    endtask

    logic [3:0] row_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    int vr0, hf0, ov0, en_low;

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        check("reset_valid", 32'(key_valid), 32'd0);

        // Idle rotation.
        for (int k = 0; k < 4; k++) wait_for("idle_rotate", 0, row_seq[k], 5);
        check("idle_no_valid", 32'(valid_rises), 32'd0);

        // Key 0xA: row 2, column 2.
        wait_for("wait_row2", 0, 4'b1011, 20);
        step(); pressed[4'hA] = 1'b1;
        wait_for("accept_A", 1, 4'h1, 60);
        check("code_A", key_code, 4'hA);
        check("held_A", key_held, 1'b1);
        check("frozen_row", row_n, 4'b1011);
        step(); pressed = '0;
        wait_for("release_A", 2, 4'h0, 60);
        pulse_ready();
        check("consume_A", key_valid, 1'b0);

        // Two-tick glitch must not produce a key; scanning moves on to row 3.
        vr0 = valid_rises;
        wait_for("wait_row2_g", 0, 4'b1011, 20);
        step(); pressed[4'hA] = 1'b1;
        repeat (8) step();
        pressed = '0;
        wait_for("glitch_next_row3", 0, 4'b0111, 12);
        check("glitch_no_valid", 32'(valid_rises), 32'(vr0));

        // Unconsumed 0x5 followed by 0xF: one overflow pulse.
        ov0 = ovf_seen;
        step(); pressed[4'h5] = 1'b1;
        wait_for("accept_5", 2, 4'h1, 60);
        check("code_5", key_code, 4'h5);
        step(); pressed = '0;
        wait_for("release_5", 2, 4'h0, 60);
        step(); pressed[4'hF] = 1'b1;
        wait_for("accept_F", 2, 4'h1, 60);
        repeat (2) @(negedge clk);
        check("code_F", key_code, 4'hF);
        check("valid_kept", key_valid, 1'b1);
        check("ovf_once", 32'(ovf_seen - ov0), 32'd1);
        step(); pressed = '0;
        wait_for("release_F", 2, 4'h0, 60);
        pulse_ready();
        check("consume_F", key_valid, 1'b0);

        // Short release inside a hold is absorbed.
        step(); pressed[4'h6] = 1'b1;
        wait_for("accept_6", 2, 4'h1, 60);
        pulse_ready();
        vr0 = valid_rises;
        hf0 = held_falls;
        step(); pressed = '0;
        repeat (7) step();
        pressed[4'h6] = 1'b1;
        repeat (40) step();
        check("bounce_held", key_held, 1'b1);
        check("bounce_no_fall", 32'(held_falls), 32'(hf0));
        check("bounce_no_valid", 32'(valid_rises), 32'(vr0));
        step(); pressed = '0;
        wait_for("release_6", 2, 4'h0, 60);

        // Enable drop during debounce.
        vr0 = valid_rises;
        wait_for("wait_row2_e", 0, 4'b1011, 20);
        step(); pressed[4'hA] = 1'b1;
        repeat (6) step();
        en = 1'b0;
        step();
        check("en_off_rows", row_n, 4'b1111);
        pressed = '0;
        repeat (4) step();
        check("en_off_no_key", 32'(valid_rises), 32'(vr0));
        en = 1'b1;
        step();
        check("en_on_row0", row_n, 4'b1110);

        // Reset while a key is pending.
        step(); pressed[4'h3] = 1'b1;
        wait_for("accept_3", 1, 4'h1, 60);
        step(); reset_n = 1'b0;
        step();
        check("rst_row", row_n, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        pressed = '0;
        reset_n = 1'b1;

        // Randomized traffic, checked cycle by cycle against the reference.
        en_low = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            key_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pressed = '0;
                    3:       pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                    default: pressed = 16'h0001 << $urandom_range(0, 15);
                endcase
            end
            if (en_low > 0) begin
                en_low--;
                en = (en_low == 0);
            end else if ($urandom_range(0, 499) == 0) begin
                en = 1'b0;
                en_low = $urandom_range(1, 10);
            end
            reset_n = ($urandom_range(0, 1999) != 0);
        end
        step();
        reset_n = 1'b1;
        en = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
